// File: rtl/spinner_emu.sv
// Converts held up/down joystick directions into a 2-bit quadrature dial phase,
// with a step rate that accelerates from SLOW_TICKS down to FAST_TICKS while held.
module spinner_emu #(
    parameter int TICK_DIV   = 12000,
    parameter int SLOW_TICKS = 40,
    parameter int FAST_TICKS = 8,
    parameter int ACCEL      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       invert,
    input  logic       up,
    input  logic       down,
    output logic [1:0] dial,
    output logic       step,
    output logic       dir,
    output logic       moving
);

    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {IDLE, RUN_CW, RUN_CCW} state_t;

    state_t        state_q, state_d, reqState;
    logic          enableR_q, invertR_q, upR_q, downR_q;
    logic [PW-1:0] pre_q;
    logic [1:0]    index_q, index_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    period_q, period_d, periodShrunk;
    logic          step_q, step_d;
    logic          dir_q, dir_d;
    logic          tick, reqCw, reqCcw, hasReq;

    assign tick = (pre_q == PW'(TICK_DIV - 1));

    // down wins when both are held; the invert swap is applied after that priority
    assign reqCw    = invertR_q ? (upR_q & ~downR_q) : downR_q;
    assign reqCcw   = invertR_q ? downR_q : (upR_q & ~downR_q);
    assign hasReq   = reqCw | reqCcw;
    assign reqState = reqCw ? RUN_CW : RUN_CCW;

    always_comb begin
        if (int'(period_q) - ACCEL > FAST_TICKS) begin
            periodShrunk = period_q - 8'(ACCEL);
        end else begin
            periodShrunk = 8'(FAST_TICKS);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            enableR_q <= 1'b0;
            invertR_q <= 1'b0;
            upR_q     <= 1'b0;
            downR_q   <= 1'b0;
            pre_q     <= '0;
            state_q   <= IDLE;
            index_q   <= 2'd0;
            cnt_q     <= 8'd0;
            period_q  <= 8'(SLOW_TICKS);
            step_q    <= 1'b0;
            dir_q     <= 1'b0;
        end else begin
            enableR_q <= enable;
            invertR_q <= invert;
            upR_q     <= up;
            downR_q   <= down;
            pre_q     <= tick ? '0 : pre_q + 1'b1;
            state_q   <= state_d;
            index_q   <= index_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            step_q    <= step_d;
            dir_q     <= dir_d;
        end
    end

    // A request that differs from the running direction (including from IDLE) is a
    // fresh press: it steps at once and restarts the slow period, even on a tick.
    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        step_d   = 1'b0;
        dir_d    = dir_q;
        if (!enableR_q) begin
            state_d  = IDLE;
            index_d  = 2'd0;
            cnt_d    = 8'd0;
            period_d = 8'(SLOW_TICKS);
        end else if (!hasReq) begin
            state_d  = IDLE;
            cnt_d    = 8'd0;
            period_d = 8'(SLOW_TICKS);
        end else if (state_q != reqState) begin
            state_d  = reqState;
            index_d  = reqCw ? index_q + 2'd1 : index_q - 2'd1;
            cnt_d    = 8'd0;
            period_d = 8'(SLOW_TICKS);
            step_d   = 1'b1;
            dir_d    = reqCw;
        end else if (tick) begin
            if (cnt_q == period_q - 8'd1) begin
                index_d  = reqCw ? index_q + 2'd1 : index_q - 2'd1;
                cnt_d    = 8'd0;
                period_d = periodShrunk;
                step_d   = 1'b1;
                dir_d    = reqCw;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        moving = (state_q != IDLE);
        dial   = 2'b11;
        case (index_q)
            2'd0: dial = 2'b11;
            2'd1: dial = 2'b10;
            2'd2: dial = 2'b00;
            2'd3: dial = 2'b01;
            default: dial = 2'b11;
        endcase
    end

    assign step = step_q;
    assign dir  = dir_q;

endmodule
